// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback requester handshakes plus the regfile write port.
interface regfile_wb_arbiter_if #(parameter int DATA_W = 32, parameter int ADDR_W = 5);
    logic              i_req0_valid;
    logic              o_req0_ready;
    logic [ADDR_W-1:0] i_req0_addr;
    logic [DATA_W-1:0] i_req0_data;
    logic              i_req1_valid;
    logic              o_req1_ready;
    logic [ADDR_W-1:0] i_req1_addr;
    logic [DATA_W-1:0] i_req1_data;
    logic [ADDR_W-1:0] o_rd_addr;
    logic [DATA_W-1:0] o_rd_data;
    logic              o_rd_wren;
    logic              o_init_done;
    logic              o_grant_id;
    modport slave (
        input  i_req0_valid, i_req0_addr, i_req0_data, i_req1_valid, i_req1_addr, i_req1_data,
        output o_req0_ready, o_req1_ready, o_rd_addr, o_rd_data, o_rd_wren, o_init_done, o_grant_id
    );
    modport master (
        output i_req0_valid, i_req0_addr, i_req0_data, i_req1_valid, i_req1_addr, i_req1_data,
        input  o_req0_ready, o_req1_ready, o_rd_addr, o_rd_data, o_rd_wren, o_init_done, o_grant_id
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: zero-fills x1..x31 after reset, then arbitrates two writeback requesters onto the regfile write port.
// Define WB_ROUND_ROBIN_EN for round-robin arbitration; otherwise req0 has fixed priority.
module regfile_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input logic i_clk,
    input logic i_reset,
    regfile_wb_arbiter_if.slave bus
);
    typedef enum logic {INIT, RUN} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              prefer1, gnt0, gnt1, xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
`ifdef WB_ROUND_ROBIN_EN
    // Holds the requester to favour at the next contention: the one not granted last.
    logic ptr_q;
    assign prefer1 = ptr_q;
    always_ff @(posedge i_clk) begin
        if (i_reset) ptr_q <= 1'b0;
        else if (xfer) ptr_q <= gnt0;
    end
`else
    assign prefer1 = 1'b0;
`endif
    always_comb begin
        state_d  = (state_q == INIT && cnt_q == LAST) ? RUN : state_q;
        cnt_d    = (state_q == INIT && cnt_q != LAST) ? cnt_q + ADDR_W'(1) : cnt_q;
        gnt0     = state_q == RUN && bus.i_req0_valid && !(bus.i_req1_valid && prefer1);
        gnt1     = state_q == RUN && bus.i_req1_valid && !(bus.i_req0_valid && !prefer1);
        xfer     = gnt0 | gnt1;
        sel_addr = gnt1 ? bus.i_req1_addr : bus.i_req0_addr;
        sel_data = gnt1 ? bus.i_req1_data : bus.i_req0_data;
    end
    assign bus.o_req0_ready = gnt0;
    assign bus.o_req1_ready = gnt1;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= INIT;
            cnt_q   <= ADDR_W'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            bus.o_rd_addr   <= '0;
            bus.o_rd_data   <= '0;
            bus.o_rd_wren   <= 1'b0;
            bus.o_grant_id  <= 1'b0;
            bus.o_init_done <= 1'b0;
        end else if (state_q == INIT) begin
            bus.o_rd_addr <= cnt_q;
            bus.o_rd_data <= '0;
            bus.o_rd_wren <= 1'b1;
        end else begin
            bus.o_init_done <= 1'b1;
            // x0 writes are accepted but never reach the regfile
            bus.o_rd_wren   <= xfer && sel_addr != '0;
            if (xfer) begin
                bus.o_rd_addr  <= sel_addr;
                bus.o_rd_data  <= sel_data;
                bus.o_grant_id <= gnt1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vector table plus randomized traffic against a reference model and a shadow regfile.
module tb_regfile_wb_arbiter;
`ifdef WB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    typedef struct {
        logic v0; logic [4:0] a0; logic [31:0] d0;
        logic v1; logic [4:0] a1; logic [31:0] d1;
        logic r0, r1, wren, chk_ad; logic [4:0] addr; logic [31:0] data; logic gid;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    regfile_wb_arbiter dut (.i_clk(clk), .i_reset(rst), .bus(bus));
    always #5 clk = ~clk;

    // shadow regfile fed by the write port, x0 hardwired to zero on read
    logic [31:0] rf [32];
    always @(posedge clk) if (bus.o_rd_wren) rf[bus.o_rd_addr] <= bus.o_rd_data;
    function automatic logic [31:0] rd(input int a);
        return a == 0 ? 32'h0 : rf[a];
    endfunction

    // reference model state
    logic [31:0] ref_rf [32];
    int k, last_gnt;
    logic exp_wren, exp_gid, chk_ad;
    logic [4:0] exp_addr;
    logic [31:0] exp_data;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                                input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                                input logic r0, input logic r1, input logic wren, input logic ca,
                                input logic [4:0] addr, input logic [31:0] data, input logic gid);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.r0 = r0; v.r1 = r1; v.wren = wren; v.chk_ad = ca; v.addr = addr; v.data = data; v.gid = gid;
        return v;
    endfunction

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        bus.i_req0_valid = v0; bus.i_req0_addr = a0; bus.i_req0_data = d0;
        bus.i_req1_valid = v1; bus.i_req1_addr = a1; bus.i_req1_data = d1;
    endtask

    task automatic do_reset(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                            input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        drive(v0, a0, d0, v1, a1, d1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("reset ready0", 32'(bus.o_req0_ready), 0);
        chk("reset ready1", 32'(bus.o_req1_ready), 0);
        chk("reset wren", 32'(bus.o_rd_wren), 0);
        chk("reset addr", 32'(bus.o_rd_addr), 0);
        chk("reset data", bus.o_rd_data, 0);
        chk("reset init_done", 32'(bus.o_init_done), 0);
        chk("reset grant_id", 32'(bus.o_grant_id), 0);
        k = 0; last_gnt = -1; exp_addr = 0; exp_data = 0; exp_gid = 0; chk_ad = 1'b1;
        #1;
    endtask

    // one model-checked cycle; starts and ends 3 time units after a rising edge
    task automatic cycle(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                         output logic g0, output logic g1);
        logic [4:0] a;
        drive(v0, a0, d0, v1, a1, d1);
        g0 = 1'b0; g1 = 1'b0;
        if (k >= 31) begin
            if (v0 && v1) begin
                g1 = RR && last_gnt == 0;
                g0 = !g1;
            end else begin
                g0 = v0; g1 = v1;
            end
        end
        #1;
        chk("ready0", 32'(bus.o_req0_ready), 32'(g0));
        chk("ready1", 32'(bus.o_req1_ready), 32'(g1));
        @(posedge clk); #1;
        if (k < 31) begin
            exp_wren = 1'b1; exp_addr = 5'(k + 1); exp_data = 0; ref_rf[k + 1] = 0; chk_ad = 1'b1;
        end else if (g0 || g1) begin
            a = g1 ? a1 : a0;
            exp_wren = a != 0;
            exp_gid = g1;
            last_gnt = g1 ? 1 : 0;
            chk_ad = a != 0;
            if (a != 0) begin
                exp_addr = a; exp_data = g1 ? d1 : d0; ref_rf[a] = exp_data;
            end
        end else exp_wren = 1'b0;
        k++;
        chk("wren", 32'(bus.o_rd_wren), 32'(exp_wren));
        if (chk_ad) begin
            chk("addr", 32'(bus.o_rd_addr), 32'(exp_addr));
            chk("data", bus.o_rd_data, exp_data);
        end
        chk("grant_id", 32'(bus.o_grant_id), 32'(exp_gid));
        chk("init_done", 32'(bus.o_init_done), 32'(k >= 32));
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [11];
        logic g0, g1, p0, p1;
        logic [4:0] pa0, pa1;
        logic [31:0] pd0, pd1;
        tbl[0]  = mk(1, 10, 32'h12345678, 1, 31, 32'hCAFEBABE, 1, 0, 1, 1, 10, 32'h12345678, 0);
        tbl[1]  = mk(0, 10, 32'h12345678, 1, 31, 32'hCAFEBABE, 0, 1, 1, 1, 31, 32'hCAFEBABE, 1);
        tbl[2]  = mk(1, 10, 32'h12345678, 1, 31, 32'hCAFEBABE, 1, 0, 1, 1, 10, 32'h12345678, 0);
`ifdef WB_ROUND_ROBIN_EN
        tbl[3]  = mk(1, 7, 32'h00000077, 1, 31, 32'hCAFEBABE, 0, 1, 1, 1, 31, 32'hCAFEBABE, 1);
        tbl[4]  = mk(1, 7, 32'h00000077, 0, 31, 32'hCAFEBABE, 1, 0, 1, 1, 7, 32'h00000077, 0);
`else
        tbl[3]  = mk(1, 7, 32'h00000077, 1, 31, 32'hCAFEBABE, 1, 0, 1, 1, 7, 32'h00000077, 0);
        tbl[4]  = mk(0, 7, 32'h00000077, 1, 31, 32'hCAFEBABE, 0, 1, 1, 1, 31, 32'hCAFEBABE, 1);
`endif
        tbl[5]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 0, 1, 1, 5, 32'hDEADBEEF, 0);
        tbl[6]  = mk(0, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0);
        tbl[7]  = mk(0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 1, 0, 0, 0, 0, 1);
        tbl[8]  = mk(1, 15, 32'h55AA55AA, 1, 15, 32'h0A0A0A0A, 1, 0, 1, 1, 15, 32'h55AA55AA, 0);
        tbl[9]  = mk(0, 15, 32'h55AA55AA, 1, 15, 32'h0A0A0A0A, 0, 1, 1, 1, 15, 32'h0A0A0A0A, 1);
        tbl[10] = mk(0, 15, 32'h55AA55AA, 0, 15, 32'h0A0A0A0A, 0, 0, 0, 1, 15, 32'h0A0A0A0A, 1);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        do_reset(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 33; i++) cycle(0, 0, 0, 0, 0, 0, g0, g1);
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1);
            #1;
            chk($sformatf("vec%0d ready0", i), 32'(bus.o_req0_ready), 32'(tbl[i].r0));
            chk($sformatf("vec%0d ready1", i), 32'(bus.o_req1_ready), 32'(tbl[i].r1));
            @(posedge clk); #1;
            chk($sformatf("vec%0d wren", i), 32'(bus.o_rd_wren), 32'(tbl[i].wren));
            if (tbl[i].chk_ad) begin
                chk($sformatf("vec%0d addr", i), 32'(bus.o_rd_addr), 32'(tbl[i].addr));
                chk($sformatf("vec%0d data", i), bus.o_rd_data, tbl[i].data);
            end
            chk($sformatf("vec%0d grant_id", i), 32'(bus.o_grant_id), 32'(tbl[i].gid));
            #2;
        end
        chk("x15 final", rd(15), 32'h0A0A0A0A);
        chk("x0 read", rd(0), 32'h0);
        chk("x5 read", rd(5), 32'hDEADBEEF);
        chk("x31 read", rd(31), 32'hCAFEBABE);
        chk("x10 read", rd(10), 32'h12345678);
        chk("x7 read", rd(7), 32'h00000077);
        // reset mid-RUN with req0 still asking: its write is dropped and zero-fill restarts
        do_reset(1, 5, 32'h11111111, 0, 0, 0);
        for (int i = 0; i < 33; i++) cycle(0, 0, 0, 0, 0, 0, g0, g1);
        chk("x5 after reset", rd(5), 32'h0);
        chk("x15 after reset", rd(15), 32'h0);
        p0 = 1'b0; p1 = 1'b0; pa0 = 0; pa1 = 0; pd0 = 0; pd1 = 0;
        do_reset(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            if (!p0 && $urandom_range(0, 2) != 0) begin p0 = 1'b1; pa0 = 5'($urandom); pd0 = $urandom; end
            if (!p1 && $urandom_range(0, 2) != 0) begin p1 = 1'b1; pa1 = 5'($urandom); pd1 = $urandom; end
            if (i == 200) do_reset(p0, pa0, pd0, p1, pa1, pd1);
            cycle(p0, pa0, pd0, p1, pa1, pd1, g0, g1);
            if (g0) p0 = 1'b0;
            if (g1) p1 = 1'b0;
        end
        for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0, 0, 0, g0, g1);
        for (int i = 1; i < 32; i++) chk($sformatf("rf x%0d", i), rd(i), ref_rf[i]);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
